master_ocp: RTL and testbench

- OCP master stage that sits directly upstream of the slave OCP block.
- Accepts one request at a time from a local requester: single write, burst write of 1–4 beats, or single read.
- Drives MCmd/MAddr/MData/MDataValid/MDataLast/id to the slave and collects SCmdAccept/SResp/SData.
- Returns read data, completion, error and timeout status to the requester.

---
 rtl/master_ocp_if.sv | 49 ++++
 rtl/master_ocp.sv | 238 +++++++++++++++++++++++
 tb/tb_master_ocp.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/master_ocp_if.sv
// Requester and OCP bus bundle seen by the master stage.
// Purely a wiring container: no state, no latency.
// Flow control: req_valid/req_ready on the request side, SCmdAccept/SResp on the bus side.
interface master_ocp_if #(
   parameter int DATAWIDTH    = 8,
   parameter int ADDRESSWIDTH = 32
);
   // Requester side
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_write;
   logic [1:0]                req_len;
   logic [ADDRESSWIDTH-1:0]   req_addr;
   logic [4*DATAWIDTH-1:0]    req_wdata;
   logic [1:0]                req_id;
   logic [DATAWIDTH-1:0]      rdata;
   logic                      rdata_valid;
   logic                      done;
   logic                      err;

   // OCP side
   logic [2:0]                MCmd;
   logic [ADDRESSWIDTH-1:0]   MAddr;
   logic [DATAWIDTH-1:0]      MData;
   logic                      MDataValid;
   logic                      MDataLast;
   logic                      MRespAccept;
   logic [1:0]                id;
   logic                      SCmdAccept;
   logic [1:0]                SResp;
   logic                      SRespLast;
   logic [DATAWIDTH-1:0]      SData;

   // View of the master stage itself
   modport master (
      input  req_valid, req_write, req_len, req_addr, req_wdata, req_id,
      input  SCmdAccept, SResp, SRespLast, SData,
      output req_ready, rdata, rdata_valid, done, err,
      output MCmd, MAddr, MData, MDataValid, MDataLast, MRespAccept, id
   );

   // View of everything around it: the requester plus the downstream slave
   modport slave (
      output req_valid, req_write, req_len, req_addr, req_wdata, req_id,
      output SCmdAccept, SResp, SRespLast, SData,
      input  req_ready, rdata, rdata_valid, done, err,
      input  MCmd, MAddr, MData, MDataValid, MDataLast, MRespAccept, id
   );
endinterface

// File: rtl/master_ocp.sv
// OCP master: one request at a time (single write, 1-4 beat burst write, single read) to the slave.
// Latency: command on the bus the cycle after capture; done/err/rdata_valid the cycle after the response.
// Backpressure: req_ready only in IDLE; each beat holds until SCmdAccept; TIMEOUT cycles without progress aborts.
module master_ocp #(
   parameter int DATAWIDTH    = 8,
   parameter int ADDRESSWIDTH = 32,
   parameter int TIMEOUT      = 16
) (
   input logic          clk,
   input logic          rst,
   master_ocp_if.master bus
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CMD_WR    = 3'd1,
      CMD_RD    = 3'd2,
      WAIT_RESP = 3'd3,
      RESP      = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDRESSWIDTH-1:0] base_q, base_d;
   logic [4*DATAWIDTH-1:0]  wdata_q, wdata_d;
   logic [1:0]              len_q, len_d;
   logic [1:0]              cnt_q, cnt_d;
   logic                    is_rd_q, is_rd_d;
   logic [TW-1:0]           tmo_q, tmo_d;

   logic [2:0]              mcmd_q, mcmd_d;
   logic [ADDRESSWIDTH-1:0] maddr_q, maddr_d;
   logic [DATAWIDTH-1:0]    mdata_q, mdata_d;
   logic                    mdv_q, mdv_d;
   logic                    mlast_q, mlast_d;
   logic                    mresp_q, mresp_d;
   logic [1:0]              id_q, id_d;
   logic [DATAWIDTH-1:0]    rdata_q, rdata_d;
   logic                    rdv_q, rdv_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    rdy_q, rdy_d;

   logic [1:0]              beat_nxt;
   logic                    tmo_hit;

   assign beat_nxt = cnt_q + 2'd1;
   // The timeout boundary is only honoured when no accept/response arrives in that same cycle
   assign tmo_hit  = (tmo_q == TMO_LAST);

   assign bus.req_ready   = rdy_q;
   assign bus.MCmd        = mcmd_q;
   assign bus.MAddr       = maddr_q;
   assign bus.MData       = mdata_q;
   assign bus.MDataValid  = mdv_q;
   assign bus.MDataLast   = mlast_q;
   assign bus.MRespAccept = mresp_q;
   assign bus.id          = id_q;
   assign bus.rdata       = rdata_q;
   assign bus.rdata_valid = rdv_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;

   // Next-state and next-output logic; pulses default low, everything else holds
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      wdata_d = wdata_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      is_rd_d = is_rd_q;
      tmo_d   = tmo_q;
      mcmd_d  = mcmd_q;
      maddr_d = maddr_q;
      mdata_d = mdata_q;
      mdv_d   = mdv_q;
      mlast_d = mlast_q;
      id_d    = id_q;
      rdata_d = rdata_q;
      mresp_d = 1'b0;
      rdv_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               base_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               len_d   = bus.req_write ? bus.req_len : 2'd0;
               is_rd_d = ~bus.req_write;
               id_d    = bus.req_id;
               cnt_d   = 2'd0;
               tmo_d   = '0;
               maddr_d = bus.req_addr;
               if (bus.req_write) begin
                  state_d = CMD_WR;
                  mcmd_d  = (bus.req_len == 2'd0) ? 3'b001 : {1'b1, bus.req_len};
                  mdata_d = bus.req_wdata[DATAWIDTH-1:0];
                  mdv_d   = 1'b1;
                  mlast_d = (bus.req_len == 2'd0);
               end else begin
                  state_d = CMD_RD;
                  mcmd_d  = 3'b010;
                  mdv_d   = 1'b0;
                  mlast_d = 1'b0;
               end
            end
         end

         CMD_WR: begin
            if (bus.SCmdAccept) begin
               tmo_d = '0;
               if (cnt_q == len_q) begin
                  state_d = WAIT_RESP;
                  mcmd_d  = 3'b000;
                  mdv_d   = 1'b0;
                  mlast_d = 1'b0;
               end else begin
                  cnt_d   = beat_nxt;
                  maddr_d = base_q + ADDRESSWIDTH'(beat_nxt);
                  mdata_d = wdata_q[int'(beat_nxt)*DATAWIDTH +: DATAWIDTH];
                  mlast_d = (beat_nxt == len_q);
               end
            end else if (tmo_hit) begin
               state_d = RESP;
               done_d  = 1'b1;
               err_d   = 1'b1;
               mcmd_d  = 3'b000;
               mdv_d   = 1'b0;
               mlast_d = 1'b0;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         CMD_RD: begin
            if (bus.SCmdAccept) begin
               state_d = WAIT_RESP;
               mcmd_d  = 3'b000;
               tmo_d   = '0;
            end else if (tmo_hit) begin
               state_d = RESP;
               done_d  = 1'b1;
               err_d   = 1'b1;
               mcmd_d  = 3'b000;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         WAIT_RESP: begin
            if (bus.SResp != 2'b00) begin
               state_d = RESP;
               mresp_d = 1'b1;
               done_d  = 1'b1;
               // Anything other than DVA (including the reserved 10) is an error
               err_d   = (bus.SResp != 2'b01);
               tmo_d   = '0;
               if (is_rd_q && (bus.SResp == 2'b01)) begin
                  rdata_d = bus.SData;
                  rdv_d   = 1'b1;
               end
            end else if (tmo_hit) begin
               state_d = RESP;
               done_d  = 1'b1;
               err_d   = 1'b1;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            mcmd_d  = 3'b000;
            mdv_d   = 1'b0;
            mlast_d = 1'b0;
         end
      endcase

      rdy_d = (state_d == IDLE);
   end

   // State and registered outputs; reset abandons any transaction without a done pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         wdata_q <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         is_rd_q <= 1'b0;
         tmo_q   <= '0;
         mcmd_q  <= 3'b000;
         maddr_q <= '0;
         mdata_q <= '0;
         mdv_q   <= 1'b0;
         mlast_q <= 1'b0;
         mresp_q <= 1'b0;
         id_q    <= '0;
         rdata_q <= '0;
         rdv_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         wdata_q <= wdata_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         is_rd_q <= is_rd_d;
         tmo_q   <= tmo_d;
         mcmd_q  <= mcmd_d;
         maddr_q <= maddr_d;
         mdata_q <= mdata_d;
         mdv_q   <= mdv_d;
         mlast_q <= mlast_d;
         mresp_q <= mresp_d;
         id_q    <= id_d;
         rdata_q <= rdata_d;
         rdv_q   <= rdv_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
      end
   end

endmodule

// File: tb/tb_master_ocp.sv
// Self-checking bench for master_ocp: directed plan items, then randomized transactions.
// Each transaction's expected bus activity is derived per beat from the request and slave timing.
// Slave side is modelled as per-beat accept delays plus one response delay/code.
module tb_master_ocp;

   localparam int DW  = 8;
   localparam int AW  = 32;
   localparam int TMO = 16;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   master_ocp_if #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW)) bus ();

   master_ocp #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction. dly holds the accept wait (in cycles) for beat k at [k*8 +: 8];
   // a wait of TMO or more means the slave never accepts within the timeout window.
   task automatic run_txn(input bit wr, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] rid, input logic [31:0] dly,
                          input int rdly, input logic [1:0] resp, input logic [7:0] sd);
      int         nb;
      int         d;
      bit         tmo;
      bit         eerr;
      bit         erv;
      logic [2:0] ecmd;
      logic [31:0] eaddr;
      logic [7:0]  edata;
      nb   = wr ? int'(len) + 1 : 1;
      ecmd = !wr ? 3'b010 : ((len == 2'd0) ? 3'b001 : {1'b1, len});
      tmo  = 1'b0;

      chk("idle_ready", {63'd0, bus.req_ready}, 64'd1);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_len   = len;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      bus.req_id    = rid;
      tick();
      // Scramble the request inputs: the master must work from its captured copy
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_len   = 2'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.req_id    = 2'($urandom);

      for (int k = 0; k < nb && !tmo; k++) begin
         d     = int'(dly[k*8 +: 8]);
         eaddr = addr + 32'(k);
         edata = wr ? wd[k*8 +: 8] : 8'h00;
         for (int c = 0; c <= TMO; c++) begin
            chk("cmd_phase",
                {15'd0, bus.MCmd, bus.MAddr, (wr ? bus.MData : 8'h00), bus.MDataValid,
                 bus.MDataLast, bus.id, bus.done, bus.req_ready},
                {15'd0, ecmd, eaddr, edata, wr, (wr && (k == int'(len))), rid, 1'b0, 1'b0});
            if (c == d) bus.SCmdAccept = 1'b1;
            tick();
            bus.SCmdAccept = 1'b0;
            if (c == d) break;
            if (c == TMO - 1) begin
               tmo = 1'b1;
               break;
            end
         end
      end

      if (!tmo) begin
         for (int c = 0; c <= TMO; c++) begin
            chk("wait_phase",
                {56'd0, bus.MCmd, bus.MDataValid, bus.MDataLast, bus.done, bus.MRespAccept, bus.req_ready},
                {56'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
            chk("wait_id", {62'd0, bus.id}, {62'd0, rid});
            if (c == rdly) begin
               bus.SResp     = resp;
               bus.SRespLast = 1'b1;
               bus.SData     = sd;
            end
            tick();
            bus.SResp     = 2'b00;
            bus.SRespLast = 1'b0;
            bus.SData     = 8'($urandom);
            if (c == rdly) break;
            if (c == TMO - 1) begin
               tmo = 1'b1;
               break;
            end
         end
      end

      if (tmo) begin
         chk("timeout_pulse",
             {54'd0, bus.done, bus.err, bus.MRespAccept, bus.rdata_valid, bus.MCmd,
              bus.MDataValid, bus.MDataLast, bus.req_ready},
             {54'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0});
      end else begin
         eerr = (resp != 2'b01);
         erv  = !wr && (resp == 2'b01);
         chk("resp_pulse",
             {55'd0, bus.done, bus.err, bus.MRespAccept, bus.rdata_valid, bus.MCmd,
              bus.MDataValid, bus.req_ready},
             {55'd0, 1'b1, eerr, 1'b1, erv, 3'b000, 1'b0, 1'b0});
         if (erv) chk("rdata", {56'd0, bus.rdata}, {56'd0, sd});
      end
      tick();
      chk("after_resp",
          {56'd0, bus.done, bus.err, bus.MRespAccept, bus.rdata_valid, bus.req_ready, bus.MCmd},
          {56'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000});
   endtask

   initial begin
      logic [31:0] rdl;
      logic [1:0]  rsp;
      int          rdly;
      checks   = 0;
      failures = 0;
      rst           = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_len   = 2'b00;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_id    = 2'b00;
      bus.SCmdAccept = 1'b0;
      bus.SResp     = 2'b00;
      bus.SRespLast = 1'b0;
      bus.SData     = '0;

      // Reset state
      #12;
      chk("reset_outputs",
          {bus.MCmd, bus.MAddr, bus.MData, bus.MDataValid, bus.MDataLast, bus.MRespAccept,
           bus.id, bus.rdata, bus.rdata_valid, bus.done, bus.err},
          64'd0);
      rst = 1'b1;
      tick();
      chk("ready_after_reset", {63'd0, bus.req_ready}, 64'd1);

      // Slave activity while idle must be ignored
      bus.SCmdAccept = 1'b1;
      bus.SResp      = 2'b01;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_noise",
             {58'd0, bus.MCmd, bus.done, bus.MRespAccept, bus.req_ready},
             {58'd0, 3'b000, 1'b0, 1'b0, 1'b1});
      end
      bus.SCmdAccept = 1'b0;
      bus.SResp      = 2'b00;

      // Single write, accepted after 2 cycles, DVA
      run_txn(1'b1, 2'd0, 32'h10, 32'h000000A5, 2'd1, 32'h00000002, 0, 2'b01, 8'h00);
      // Burst of 4 wrapping the address space, accept every other cycle
      run_txn(1'b1, 2'd3, 32'hFFFFFFFE, 32'h44332211, 2'd2, 32'h01010101, 1, 2'b01, 8'h00);
      // Read, accept after 3 cycles, DVA with data
      run_txn(1'b0, 2'd3, 32'h40, 32'h0, 2'd3, 32'h00000003, 2, 2'b01, 8'h3C);
      // Read with ERR response
      run_txn(1'b0, 2'd0, 32'h44, 32'h0, 2'd0, 32'h00000000, 0, 2'b11, 8'h77);
      // Reserved response code treated as error
      run_txn(1'b1, 2'd1, 32'h80, 32'h0000BEEF, 2'd1, 32'h00000000, 3, 2'b10, 8'h00);
      // Command never accepted: abort on the 16th cycle
      run_txn(1'b1, 2'd0, 32'h90, 32'h0000005A, 2'd2, 32'h000000C8, 0, 2'b01, 8'h00);
      // Accept arrives exactly on the timeout boundary: no abort
      run_txn(1'b0, 2'd0, 32'hA0, 32'h0, 2'd1, 32'h0000000F, 0, 2'b01, 8'hE1);
      // Burst whose third beat stalls forever
      run_txn(1'b1, 2'd3, 32'hB0, 32'hDDCCBBAA, 2'd3, 32'h00C80000, 0, 2'b01, 8'h00);
      // Response boundary: arrives on the last allowed cycle, then one that never comes
      run_txn(1'b0, 2'd0, 32'hC0, 32'h0, 2'd0, 32'h00000001, 15, 2'b01, 8'h5D);
      run_txn(1'b0, 2'd0, 32'hC4, 32'h0, 2'd0, 32'h00000001, 40, 2'b01, 8'h5E);

      // Reset in the middle of a burst after the first beat is accepted
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_len   = 2'd3;
      bus.req_addr  = 32'h100;
      bus.req_wdata = 32'h04030201;
      bus.req_id    = 2'd2;
      tick();
      bus.req_valid  = 1'b0;
      bus.SCmdAccept = 1'b1;
      tick();
      bus.SCmdAccept = 1'b0;
      chk("burst_beat1", {24'd0, bus.MAddr, bus.MData}, {24'd0, 32'h101, 8'h02});
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset",
          {bus.MCmd, bus.MAddr, bus.MData, bus.MDataValid, bus.MDataLast, bus.MRespAccept,
           bus.id, bus.rdata, bus.rdata_valid, bus.done, bus.err},
          64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_no_done", {62'd0, bus.done, bus.MDataValid}, 64'd0);
      end
      rst = 1'b1;
      tick();
      chk("ready_after_midreset", {63'd0, bus.req_ready}, 64'd1);
      run_txn(1'b1, 2'd0, 32'h200, 32'h000000C3, 2'd1, 32'h00000001, 1, 2'b01, 8'h00);

      // Randomized transactions, back-to-back
      for (int t = 0; t < 40; t++) begin
         rdl = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
         if ($urandom_range(0, 7) == 0) rdl[8*$urandom_range(0, 3) +: 8] = 8'($urandom_range(14, 18));
         rdly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       rsp = 2'b11;
            1:       rsp = 2'b10;
            default: rsp = 2'b01;
         endcase
         run_txn(1'($urandom), 2'($urandom), $urandom, $urandom, 2'($urandom), rdl, rdly, rsp,
                 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
